// File: rtl/gbus_collect_pkg.sv
// Shared widths, the buffered entry layout and the round-robin pointer helper
// for the global-bus read collector.
package gbus_collect_pkg;
    localparam int H_NUM_DEF     = 8;
    localparam int V_NUM_DEF     = 8;
    localparam int GBUS_DATA_DEF = 64;
    localparam int ROW_W         = $clog2(H_NUM_DEF);
    localparam int COL_W         = $clog2(V_NUM_DEF);

    typedef struct packed {
        logic [GBUS_DATA_DEF-1:0] data;
        logic [COL_W-1:0]         col;
    } gbus_entry_t;

    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction
endpackage

// File: rtl/gbus_row_fifo.sv
// Per-row synchronous FIFO; a push on full is taken only alongside a pop.
module gbus_row_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         almost_full
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty       = (cnt_q == '0);
    assign full        = (cnt_q == (AW+1)'(DEPTH));
    assign almost_full = (cnt_q >= (AW+1)'(DEPTH - 1));
    assign rdata       = mem_q[rd_ptr_q];
    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/gbus_rd_collector.sv
// Collects per-row gbus read-back words into row FIFOs and drains them
// round-robin into one registered valid/ready stream.
module gbus_rd_collector
    import gbus_collect_pkg::*;
#(
    parameter int H_NUM      = H_NUM_DEF,
    parameter int V_NUM      = V_NUM_DEF,
    parameter int GBUS_DATA  = GBUS_DATA_DEF,
    parameter int FIFO_DEPTH = 4,
    localparam int RW        = $clog2(H_NUM),
    localparam int CW        = $clog2(V_NUM)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [H_NUM-1:0][GBUS_DATA-1:0]  gbus_rdata,
    input  logic [H_NUM-1:0][V_NUM-1:0]      gbus_rvalid,
    output logic [GBUS_DATA-1:0]             out_data,
    output logic [RW-1:0]                    out_row,
    output logic [CW-1:0]                    out_col,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [H_NUM-1:0]                 row_almost_full,
    output logic                             overflow_err,
    output logic                             multi_hit_err,
    input  logic                             clr_err
);
    localparam int EW = GBUS_DATA + CW;

    logic [H_NUM-1:0]         push, pop, full, empty, hit_multi, drop;
    logic [H_NUM-1:0][CW-1:0] cap_col;
    logic [H_NUM-1:0][EW-1:0] fifo_rdata;
    logic                     gnt_vld, load;
    logic [RW-1:0]            gnt_idx, rr_q, rr_d;
    logic                     out_valid_q, out_valid_d;
    logic [GBUS_DATA-1:0]     out_data_q;
    logic [RW-1:0]            out_row_q;
    logic [CW-1:0]            out_col_q;
    logic                     ovf_q, ovf_d, mhit_q, mhit_d;

    // Lowest set bit wins, matching the array's own rdata mux priority.
    always_comb begin
        for (int r = 0; r < H_NUM; r++) begin
            cap_col[r] = '0;
            for (int c = V_NUM - 1; c >= 0; c--)
                if (gbus_rvalid[r][c]) cap_col[r] = CW'(c);
            push[r]      = |gbus_rvalid[r];
            hit_multi[r] = |(gbus_rvalid[r] & (gbus_rvalid[r] - V_NUM'(1)));
            drop[r]      = push[r] && full[r] && !pop[r];
        end
    end

    for (genvar r = 0; r < H_NUM; r++) begin : g_row
        gbus_row_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (push[r]),
            .pop         (pop[r]),
            .wdata       ({gbus_rdata[r], cap_col[r]}),
            .rdata       (fifo_rdata[r]),
            .full        (full[r]),
            .empty       (empty[r]),
            .almost_full (row_almost_full[r])
        );
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < H_NUM; i++) begin
            if (!gnt_vld && !empty[(int'(rr_q) + i) % H_NUM]) begin
                gnt_vld = 1'b1;
                gnt_idx = RW'((int'(rr_q) + i) % H_NUM);
            end
        end
        load = gnt_vld && (!out_valid_q || out_ready);
        pop  = '0;
        if (load) pop[gnt_idx] = 1'b1;
        rr_d        = load ? RW'(rr_next(int'(gnt_idx), H_NUM)) : rr_q;
        out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        ovf_d       = (|drop) ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        mhit_d      = (|hit_multi) ? 1'b1 : (clr_err ? 1'b0 : mhit_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            ovf_q       <= 1'b0;
            mhit_q      <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            mhit_q      <= mhit_d;
            if (load) begin
                out_data_q <= fifo_rdata[gnt_idx][EW-1:CW];
                out_col_q  <= fifo_rdata[gnt_idx][CW-1:0];
                out_row_q  <= gnt_idx;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_row       = out_row_q;
    assign out_col       = out_col_q;
    assign overflow_err  = ovf_q;
    assign multi_hit_err = mhit_q;
endmodule
